// File: rtl/verin_pwm_drive_if.sv
// Control and status bundle between the direction/PWM PIOs and the bridge driver.
interface verin_pwm_drive_if #(
  parameter int CNT_W = 16
) ();
  logic             enable;
  logic             sens_in;
  logic [CNT_W-1:0] freq;
  logic [CNT_W-1:0] duty;
  logic             pwm_out;
  logic             sens_out;
  logic             reversing;
  logic             period_start;

  modport master (
    output enable, sens_in, freq, duty,
    input  pwm_out, sens_out, reversing, period_start
  );

  modport slave (
    input  enable, sens_in, freq, duty,
    output pwm_out, sens_out, reversing, period_start
  );
endinterface

// File: rtl/verin_pwm_drive.sv
// H-bridge PWM driver for the actuator motor; every direction reversal is
// preceded by DEAD_CYCLES clocks with the bridge switched off.
module verin_pwm_drive #(
  parameter int CNT_W       = 16,
  parameter int DEAD_CYCLES = 50
) (
  input logic              clk,
  input logic              reset,
  verin_pwm_drive_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DEAD = 2'd2
  } state_t;

  localparam logic [15:0]      DEAD_INIT = 16'(DEAD_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO       = CNT_W'(2);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] freq_l_q, freq_l_d;
  logic [CNT_W-1:0] duty_l_q, duty_l_d;
  logic [15:0]      dead_cnt_q, dead_cnt_d;
  logic             pwm_q, pwm_d;
  logic             sens_q, sens_d;
  logic             rev_q, rev_d;
  logic             ps_q, ps_d;
  logic             freq_ok;

  // Periods shorter than two clocks are treated as "not running": no pulse, no PWM.
  assign freq_ok = (bus.freq >= TWO);

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    freq_l_d   = freq_l_q;
    duty_l_d   = duty_l_q;
    dead_cnt_d = dead_cnt_q;
    pwm_d      = 1'b0;
    sens_d     = sens_q;
    rev_d      = 1'b0;
    ps_d       = 1'b0;
    case (state_q)
      IDLE: begin
        sens_d     = bus.sens_in;
        cnt_d      = '0;
        dead_cnt_d = 16'd0;
        if (bus.enable) begin
          state_d  = RUN;
          freq_l_d = bus.freq;
          duty_l_d = bus.duty;
          ps_d     = freq_ok;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (!bus.enable) begin
          state_d    = IDLE;
          cnt_d      = '0;
          dead_cnt_d = 16'd0;
        end else if (bus.sens_in != sens_q) begin
          state_d    = DEAD;
          rev_d      = 1'b1;
          dead_cnt_d = DEAD_INIT;
          cnt_d      = '0;
        end else if (freq_l_q < TWO) begin
          cnt_d    = '0;
          freq_l_d = bus.freq;
          duty_l_d = bus.duty;
          ps_d     = freq_ok;
        end else begin
          pwm_d = (cnt_q < duty_l_q);
          // New period values are only taken at the wrap so no period is glitched.
          if (cnt_q == freq_l_q - ONE) begin
            cnt_d    = '0;
            freq_l_d = bus.freq;
            duty_l_d = bus.duty;
            ps_d     = freq_ok;
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end
      end
      DEAD: begin
        if (!bus.enable) begin
          state_d    = IDLE;
          cnt_d      = '0;
          dead_cnt_d = 16'd0;
        end else if (dead_cnt_q == 16'd0) begin
          state_d  = RUN;
          sens_d   = bus.sens_in;
          cnt_d    = '0;
          freq_l_d = bus.freq;
          duty_l_d = bus.duty;
          ps_d     = freq_ok;
        end else begin
          rev_d      = 1'b1;
          dead_cnt_d = dead_cnt_q - 16'd1;
        end
      end
      default: begin
        state_d    = IDLE;
        cnt_d      = '0;
        dead_cnt_d = 16'd0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      freq_l_q   <= '0;
      duty_l_q   <= '0;
      dead_cnt_q <= 16'd0;
      pwm_q      <= 1'b0;
      sens_q     <= 1'b0;
      rev_q      <= 1'b0;
      ps_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      freq_l_q   <= freq_l_d;
      duty_l_q   <= duty_l_d;
      dead_cnt_q <= dead_cnt_d;
      pwm_q      <= pwm_d;
      sens_q     <= sens_d;
      rev_q      <= rev_d;
      ps_q       <= ps_d;
    end
  end

  assign bus.pwm_out      = pwm_q;
  assign bus.sens_out     = sens_q;
  assign bus.reversing    = rev_q;
  assign bus.period_start = ps_q;

  verin_pwm_drive_chk u_chk (
    .clk      (clk),
    .reset    (reset),
    .pwm_out  (pwm_q),
    .sens_out (sens_q)
  );

endmodule

// Bridge shoot-through guard: direction may only move after a low PWM cycle.
module verin_pwm_drive_chk (
  input logic clk,
  input logic reset,
  input logic pwm_out,
  input logic sens_out
);
  a_no_overlap: assert property (@(posedge clk) disable iff (reset)
    $changed(sens_out) |-> !$past(pwm_out));
endmodule

// File: tb/tb_verin_pwm_drive.sv
// Directed bench for verin_pwm_drive: period/duty shaping, dead time, boundaries, reset.
module tb_verin_pwm_drive;
  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   errors   = 0;
  int   overlaps = 0;
  logic prev_pwm   = 1'b0;
  logic prev_sens  = 1'b0;
  logic prev_valid = 1'b0;
  int   h, p, r;

  verin_pwm_drive_if #(.CNT_W(16)) bus ();

  verin_pwm_drive #(.CNT_W(16), .DEAD_CYCLES(50)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_ps(input int budget, input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (bus.period_start === 1'b1) seen = 1'b1;
    end
    chk(tag, {31'd0, seen}, 32'd1);
  endtask

  // Samples n negedges; optional input change after sample chg_at.
  task automatic window(input int n, input int chg_at, input logic chg_sens,
                        input logic [15:0] chg_duty,
                        output int highs, output int pulses, output int revs);
    highs = 0; pulses = 0; revs = 0;
    for (int s = 1; s <= n; s++) begin
      @(negedge clk);
      if (bus.pwm_out === 1'b1) highs++;
      if (bus.period_start === 1'b1) pulses++;
      if (bus.reversing === 1'b1) revs++;
      if (s == chg_at) begin
        bus.sens_in = chg_sens;
        bus.duty    = chg_duty;
      end
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      prev_valid <= 1'b0;
    end else begin
      if (prev_valid && bus.sens_out !== prev_sens && prev_pwm === 1'b1)
        overlaps <= overlaps + 1;
      prev_valid <= 1'b1;
    end
    prev_pwm  <= bus.pwm_out;
    prev_sens <= bus.sens_out;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset        = 1'b1;
    bus.enable   = 1'b0;
    bus.sens_in  = 1'b0;
    bus.freq     = 16'd10;
    bus.duty     = 16'd3;
    @(negedge clk);
    chk("rst_pwm", {31'd0, bus.pwm_out}, 32'd0);
    chk("rst_sens", {31'd0, bus.sens_out}, 32'd0);
    chk("rst_rev", {31'd0, bus.reversing}, 32'd0);
    chk("rst_ps", {31'd0, bus.period_start}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_pwm", {31'd0, bus.pwm_out}, 32'd0);
    chk("idle_ps", {31'd0, bus.period_start}, 32'd0);

    // Basic 10-cycle period, 3 high.
    bus.enable = 1'b1;
    wait_ps(3, "t1_start_ps");
    chk("t1_first_pwm", {31'd0, bus.pwm_out}, 32'd0);
    window(10, 0, 1'b0, 16'd3, h, p, r);
    chk("t1_high_a", h, 32'd3);
    chk("t1_ps_a", p, 32'd1);
    window(10, 0, 1'b0, 16'd3, h, p, r);
    chk("t1_high_b", h, 32'd3);
    chk("t1_ps_b", p, 32'd1);
    chk("t1_rev", r, 32'd0);
    chk("t1_sens", {31'd0, bus.sens_out}, 32'd0);

    // Duty change mid-period applies at the next boundary.
    window(10, 4, 1'b0, 16'd7, h, p, r);
    chk("t2_high_old", h, 32'd3);
    chk("t2_ps_old", p, 32'd1);
    window(10, 0, 1'b0, 16'd7, h, p, r);
    chk("t2_high_new", h, 32'd7);
    chk("t2_ps_new", p, 32'd1);

    // Reversal 0->1.
    bus.sens_in = 1'b1;
    window(50, 0, 1'b1, 16'd7, h, p, r);
    chk("t3_dead_pwm", h, 32'd0);
    chk("t3_dead_rev", r, 32'd50);
    chk("t3_dead_ps", p, 32'd0);
    chk("t3_sens_held", {31'd0, bus.sens_out}, 32'd0);
    @(negedge clk);
    chk("t3_sens_new", {31'd0, bus.sens_out}, 32'd1);
    chk("t3_rev_off", {31'd0, bus.reversing}, 32'd0);
    chk("t3_ps", {31'd0, bus.period_start}, 32'd1);
    window(10, 0, 1'b1, 16'd7, h, p, r);
    chk("t3_resume_high", h, 32'd7);
    chk("t3_resume_ps", p, 32'd1);

    // Reversal request withdrawn at cycle 20 of the dead time.
    bus.sens_in = 1'b0;
    window(50, 20, 1'b1, 16'd7, h, p, r);
    chk("t4_dead_pwm", h, 32'd0);
    chk("t4_dead_rev", r, 32'd50);
    @(negedge clk);
    chk("t4_sens_kept", {31'd0, bus.sens_out}, 32'd1);
    chk("t4_rev_off", {31'd0, bus.reversing}, 32'd0);
    chk("t4_ps", {31'd0, bus.period_start}, 32'd1);
    window(10, 0, 1'b1, 16'd7, h, p, r);
    chk("t4_resume_high", h, 32'd7);

    // Boundaries: duty > freq, duty 0, freq 1.
    bus.duty = 16'd12;
    window(10, 0, 1'b1, 16'd12, h, p, r);
    chk("t5_pre_full", h, 32'd7);
    window(10, 0, 1'b1, 16'd12, h, p, r);
    chk("t5_full_high", h, 32'd10);
    chk("t5_full_ps", p, 32'd1);
    bus.duty = 16'd0;
    window(10, 0, 1'b1, 16'd0, h, p, r);
    chk("t5_pre_zero", h, 32'd10);
    window(10, 0, 1'b1, 16'd0, h, p, r);
    chk("t5_zero_high", h, 32'd0);
    chk("t5_zero_ps", p, 32'd1);
    bus.freq = 16'd1;
    bus.duty = 16'd5;
    window(10, 0, 1'b1, 16'd5, h, p, r);
    chk("t5_pre_f1_ps", p, 32'd0);
    window(20, 0, 1'b1, 16'd5, h, p, r);
    chk("t5_f1_high", h, 32'd0);
    chk("t5_f1_ps", p, 32'd0);
    bus.freq = 16'd10;
    bus.duty = 16'd3;
    wait_ps(5, "t5_restart_ps");
    window(10, 0, 1'b1, 16'd3, h, p, r);
    chk("t5_restart_high", h, 32'd3);

    // Disable mid-RUN.
    @(negedge clk);
    @(negedge clk);
    chk("t6_pwm_on", {31'd0, bus.pwm_out}, 32'd1);
    bus.enable  = 1'b0;
    bus.sens_in = 1'b0;
    @(negedge clk);
    chk("t6_pwm_off", {31'd0, bus.pwm_out}, 32'd0);
    chk("t6_sens_hold", {31'd0, bus.sens_out}, 32'd1);
    chk("t6_rev", {31'd0, bus.reversing}, 32'd0);
    @(negedge clk);
    chk("t6_track0", {31'd0, bus.sens_out}, 32'd0);
    bus.sens_in = 1'b1;
    @(negedge clk);
    chk("t6_track1", {31'd0, bus.sens_out}, 32'd1);

    // Enable with simultaneous direction change: no dead time.
    bus.enable  = 1'b1;
    bus.sens_in = 1'b0;
    @(negedge clk);
    chk("t7_sens_direct", {31'd0, bus.sens_out}, 32'd0);
    chk("t7_rev", {31'd0, bus.reversing}, 32'd0);
    chk("t7_ps", {31'd0, bus.period_start}, 32'd1);
    window(10, 0, 1'b0, 16'd3, h, p, r);
    chk("t7_high", h, 32'd3);

    // Async reset in the middle of a dead time.
    bus.sens_in = 1'b1;
    repeat (10) @(negedge clk);
    chk("t8_in_dead", {31'd0, bus.reversing}, 32'd1);
    reset = 1'b1;
    #1;
    chk("t8_rst_pwm", {31'd0, bus.pwm_out}, 32'd0);
    chk("t8_rst_sens", {31'd0, bus.sens_out}, 32'd0);
    chk("t8_rst_rev", {31'd0, bus.reversing}, 32'd0);
    chk("t8_rst_ps", {31'd0, bus.period_start}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset      = 1'b0;
    bus.enable = 1'b0;
    @(negedge clk);
    chk("t8_idle_track", {31'd0, bus.sens_out}, 32'd1);
    chk("t8_idle_rev", {31'd0, bus.reversing}, 32'd0);
    bus.enable = 1'b1;
    @(negedge clk);
    chk("t8_reenable_ps", {31'd0, bus.period_start}, 32'd1);
    chk("t8_reenable_pwm", {31'd0, bus.pwm_out}, 32'd0);

    @(negedge clk);
    chk("overlap", overlaps, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
